// File: rtl/emulador_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 emulator: FSM state encodings and BCD limits.
package emulador_hcsr04_pkg;

    typedef enum logic [2:0] {
        S_ESPERA    = 3'd0,
        S_MEDE_TRIG = 3'd1,
        S_ATRASO    = 3'd2,
        S_ECHO      = 3'd3,
        S_FIM       = 3'd4
    } estado_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Out-of-range digits are clamped rather than flagged.
    function automatic logic [3:0] satura_bcd(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/contador_bcd_3digitos_dec.sv
// 3-digit BCD down-counter with synchronous load, count enable and 000/001 flags.
module contador_bcd_3digitos_dec
    import emulador_hcsr04_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_d0,
    input  logic [3:0] i_d1,
    input  logic [3:0] i_d2,
    output logic       o_zero,
    output logic       o_um
);

    logic [3:0] r_d0, r_d1, r_d2;

    // The enable is only asserted while the count is non-zero, so d2 never borrows.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else if (i_load) begin
            r_d0 <= i_d0;
            r_d1 <= i_d1;
            r_d2 <= i_d2;
        end else if (i_en) begin
            if (r_d0 != 4'd0) begin
                r_d0 <= r_d0 - 4'd1;
            end else begin
                r_d0 <= BCD_MAX;
                if (r_d1 != 4'd0) begin
                    r_d1 <= r_d1 - 4'd1;
                end else begin
                    r_d1 <= BCD_MAX;
                    r_d2 <= r_d2 - 4'd1;
                end
            end
        end
    end

    assign o_zero = (r_d2 == 4'd0) && (r_d1 == 4'd0) && (r_d0 == 4'd0);
    assign o_um   = (r_d2 == 4'd0) && (r_d1 == 4'd0) && (r_d0 == 4'd1);

endmodule

// File: rtl/emulador_hcsr04_fd.sv
// Datapath: trigger-width counter, delay counter, per-cm tick counter and latched BCD distance.
module emulador_hcsr04_fd
    import emulador_hcsr04_pkg::*;
#(
    parameter int R        = 10,
    parameter int N        = 4,
    parameter int TRIG_MIN = 10,
    parameter int ATRASO   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  estado_t    i_estado,
    input  logic [3:0] digito0,
    input  logic [3:0] digito1,
    input  logic [3:0] digito2,
    output logic       o_trig_ok,
    output logic       o_atraso_fim,
    output logic       o_dist_zero,
    output logic       o_echo_fim
);

    localparam int TW = $clog2(TRIG_MIN + 1);
    localparam int AW = (ATRASO > 1) ? $clog2(ATRASO) : 1;

    logic [TW-1:0] r_cont_trig;
    logic [AW-1:0] r_cont_atraso;
    logic [N-1:0]  r_tick;
    logic          w_tick_fim;
    logic          w_carrega;
    logic          w_dec;
    logic          w_um;

    // The sample that leaves ESPERA already counts as the first high cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cont_trig <= '0;
        end else begin
            case (i_estado)
                S_ESPERA:    r_cont_trig <= trigger ? TW'(1) : '0;
                S_MEDE_TRIG: if (trigger && (r_cont_trig < TW'(TRIG_MIN)))
                                 r_cont_trig <= r_cont_trig + TW'(1);
                default:     r_cont_trig <= '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_cont_atraso <= '0;
        else if ((i_estado == S_ATRASO) && !o_atraso_fim)
            r_cont_atraso <= r_cont_atraso + AW'(1);
        else
            r_cont_atraso <= '0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_tick <= '0;
        else if ((i_estado == S_ECHO) && !w_tick_fim)
            r_tick <= r_tick + N'(1);
        else
            r_tick <= '0;
    end

    assign w_tick_fim   = (r_tick == N'(R - 1));
    assign w_carrega    = (i_estado == S_MEDE_TRIG) && !trigger;
    assign w_dec        = (i_estado == S_ECHO) && w_tick_fim;
    assign o_trig_ok    = (r_cont_trig >= TW'(TRIG_MIN));
    assign o_atraso_fim = (r_cont_atraso == AW'(ATRASO - 1));
    assign o_echo_fim   = w_tick_fim && w_um;

    contador_bcd_3digitos_dec u_bcd (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_carrega),
        .i_en   (w_dec),
        .i_d0   (satura_bcd(digito0)),
        .i_d1   (satura_bcd(digito1)),
        .i_d2   (satura_bcd(digito2)),
        .o_zero (o_dist_zero),
        .o_um   (w_um)
    );

endmodule

// File: rtl/emulador_hcsr04_uc.sv
// Control unit: Moore FSM sequencing trigger qualification, delay, echo and end pulse.
module emulador_hcsr04_uc
    import emulador_hcsr04_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    trigger,
    input  logic    i_trig_ok,
    input  logic    i_atraso_fim,
    input  logic    i_dist_zero,
    input  logic    i_echo_fim,
    output estado_t o_estado,
    output logic    o_echo,
    output logic    o_ocupado,
    output logic    o_pronto
);

    estado_t r_estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= S_ESPERA;
        end else begin
            case (r_estado)
                S_ESPERA:    if (trigger) r_estado <= S_MEDE_TRIG;
                S_MEDE_TRIG: if (!trigger) r_estado <= i_trig_ok ? S_ATRASO : S_ESPERA;
                S_ATRASO:    if (i_atraso_fim) r_estado <= i_dist_zero ? S_FIM : S_ECHO;
                S_ECHO:      if (i_echo_fim) r_estado <= S_FIM;
                S_FIM:       r_estado <= S_ESPERA;
                default:     r_estado <= S_ESPERA;
            endcase
        end
    end

    // Outputs come straight off the state register, so they are glitch-free.
    assign o_estado  = r_estado;
    assign o_echo    = (r_estado == S_ECHO);
    assign o_pronto  = (r_estado == S_FIM);
    assign o_ocupado = (r_estado != S_ESPERA);

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 emulator: answers a qualified trigger with an echo of width distance x R clocks.
module emulador_hcsr04
    import emulador_hcsr04_pkg::*;
#(
    parameter int R        = 10,
    parameter int N        = 4,
    parameter int TRIG_MIN = 10,
    parameter int ATRASO   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       trigger,
    input  logic [3:0] digito0,
    input  logic [3:0] digito1,
    input  logic [3:0] digito2,
    output logic       echo,
    output logic       ocupado,
    output logic       pronto
);

    estado_t w_estado;
    logic    w_trig_ok, w_atraso_fim, w_dist_zero, w_echo_fim;

    emulador_hcsr04_uc u_uc (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .i_trig_ok    (w_trig_ok),
        .i_atraso_fim (w_atraso_fim),
        .i_dist_zero  (w_dist_zero),
        .i_echo_fim   (w_echo_fim),
        .o_estado     (w_estado),
        .o_echo       (echo),
        .o_ocupado    (ocupado),
        .o_pronto     (pronto)
    );

    emulador_hcsr04_fd #(
        .R        (R),
        .N        (N),
        .TRIG_MIN (TRIG_MIN),
        .ATRASO   (ATRASO)
    ) u_fd (
        .clock        (clock),
        .reset        (reset),
        .trigger      (trigger),
        .i_estado     (w_estado),
        .digito0      (digito0),
        .digito1      (digito1),
        .digito2      (digito2),
        .o_trig_ok    (w_trig_ok),
        .o_atraso_fim (w_atraso_fim),
        .o_dist_zero  (w_dist_zero),
        .o_echo_fim   (w_echo_fim)
    );

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Scoreboard bench: stimulus queues expected echo width/timing, a negedge monitor checks each pronto.
module tb_emulador_hcsr04;

    localparam int R  = 10;
    localparam int AT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       trigger = 1'b0;
    logic [3:0] digito0 = '0, digito1 = '0, digito2 = '0;
    logic       echo, ocupado, pronto;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int w;
        int t0;
    } exp_t;
    exp_t q[$];

    emulador_hcsr04 #(.R(R), .N(4), .TRIG_MIN(10), .ATRASO(AT)) dut (
        .clock   (clock),
        .reset   (reset),
        .trigger (trigger),
        .digito0 (digito0),
        .digito1 (digito1),
        .digito2 (digito2),
        .echo    (echo),
        .ocupado (ocupado),
        .pronto  (pronto)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: tracks echo rise/width and scores every pronto against the queue.
    initial begin
        int   rise, hi;
        bit   seen;
        exp_t e;
        rise = 0; hi = 0; seen = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                seen = 1'b0;
                hi   = 0;
            end else begin
                if (echo) begin
                    if (!seen) begin
                        seen = 1'b1;
                        rise = cyc;
                    end
                    hi++;
                end
                if (pronto) begin
                    if (q.size() == 0) begin
                        chk("unexpected_pronto", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("pronto_echo_low", int'(echo), 0);
                        if (e.w == 0) begin
                            chk("no_echo", int'(seen), 0);
                            chk("pronto_cycle", cyc, e.t0);
                        end else begin
                            chk("echo_rise", rise, e.t0);
                            chk("echo_width", hi, e.w);
                            chk("pronto_cycle", cyc, rise + e.w);
                        end
                    end
                    seen = 1'b0;
                    hi   = 0;
                end
            end
        end
    end

    // Drives trigger high for n sampled edges; k is the edge that first samples it low.
    task automatic pulse(input int n, output int k);
        @(posedge clock); #1 trigger = 1'b1;
        @(posedge clock); #1;
        chk("ocupado_rise", int'(ocupado), 1);
        repeat (n - 1) @(posedge clock);
        #1 trigger = 1'b0;
        k = cyc + 1;
    endtask

    task automatic meas(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                        input int n, input int cm, input bit valid, output int k);
        digito2 = d2; digito1 = d1; digito0 = d0;
        pulse(n, k);
        if (valid) q.push_back('{cm * R, k + AT});
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        do begin
            @(posedge clock); #1; t++;
        end while (ocupado && t < 15000);
        if (ocupado) chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_sig(input string name, input bit want_echo);
        int t = 0;
        while (!(want_echo ? echo : pronto) && t < 15000) begin
            @(posedge clock); #1; t++;
        end
        if (!(want_echo ? echo : pronto)) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_echo", int'(echo), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_pronto", int'(pronto), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // 25 cm, minimum-width trigger
        meas(4'd0, 4'd2, 4'd5, 10, 25, 1'b1, k);
        wait_idle("m25");

        // Trigger one cycle short: rejected
        meas(4'd0, 4'd2, 4'd5, 9, 0, 1'b0, k);
        chk("short_ocupado_mede", int'(ocupado), 1);
        @(posedge clock); #1;
        chk("short_ocupado_low", int'(ocupado), 0);
        chk("short_echo", int'(echo), 0);
        repeat (20) @(posedge clock);

        // Borrow across two digits, then the maximum distance
        meas(4'd1, 4'd0, 4'd0, 10, 100, 1'b1, k);
        wait_idle("m100");
        meas(4'd9, 4'd9, 4'd9, 10, 999, 1'b1, k);
        wait_idle("m999");

        // Zero distance, then a saturated units digit (F -> 9)
        meas(4'd0, 4'd0, 4'd0, 10, 0, 1'b1, k);
        wait_idle("m0");
        meas(4'd0, 4'd3, 4'hF, 12, 39, 1'b1, k);
        wait_idle("m39");

        // Digit change and re-trigger during echo have no effect
        meas(4'd0, 4'd2, 4'd5, 10, 25, 1'b1, k);
        wait_sig("m25b_echo", 1'b1);
        digito2 = 4'd9; digito1 = 4'd9; digito0 = 4'd9;
        pulse(12, k);
        wait_idle("m25b");

        // Reset mid-echo: echo drops on the next edge, no pronto
        meas(4'd0, 4'd2, 4'd5, 10, 0, 1'b0, k);
        wait_sig("rst_echo", 1'b1);
        repeat (50) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_echo_low", int'(echo), 0);
        chk("rst_ocupado_low", int'(ocupado), 0);
        chk("rst_pronto_low", int'(pronto), 0);
        reset = 1'b0;
        repeat (300) @(posedge clock);

        // Back-to-back: second trigger starts the cycle after pronto
        meas(4'd0, 4'd1, 4'd2, 10, 12, 1'b1, k);
        wait_sig("b2b_pronto", 1'b0);
        meas(4'd0, 4'd0, 4'd7, 10, 7, 1'b1, k);
        wait_idle("b2b");

        repeat (20) @(posedge clock);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
